// File: rtl/seq_gen.sv
// Serial pattern generator: sends a W-bit pattern MSB-first, rep times, with GAP idle bits between repetitions.
// Latency: first bit is on sout in the cycle right after the edge that accepts start.
// Backpressure: none; start is only honoured in IDLE and ignored for the rest of a job.
module seq_gen #(
    parameter int W   = 4,
    parameter int GAP = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] pattern,
    input  logic [7:0]   rep,
    output logic         sout,
    output logic         sout_valid,
    output logic         busy,
    output logic         done
);

    localparam int              BW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0]   BIT_LAST = BW'(W - 1);
    localparam logic [3:0]      GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    shadow;
    logic [W-1:0]    shreg;
    logic [BW-1:0]   bit_cnt;
    logic [7:0]      rep_cnt;
    logic [3:0]      gap_cnt;

    // sout is the registered copy of the current bit; shreg holds the bits still to come.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            shadow     <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            rep_cnt    <= '0;
            gap_cnt    <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    busy       <= 1'b0;
                    if (start) begin
                        shadow  <= pattern;
                        rep_cnt <= rep;
                        if (rep != 8'd0) begin
                            state      <= S_SHIFT;
                            sout       <= pattern[W-1];
                            sout_valid <= 1'b1;
                            busy       <= 1'b1;
                            shreg      <= {pattern[W-2:0], 1'b0};
                            bit_cnt    <= BIT_LAST;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            shreg <= pattern;
                        end
                    end
                end

                S_SHIFT: begin
                    if (bit_cnt != '0) begin
                        sout    <= shreg[W-1];
                        shreg   <= {shreg[W-2:0], 1'b0};
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt - 8'd1;
                        if (rep_cnt == 8'd1) begin
                            state      <= S_DONE;
                            sout       <= 1'b0;
                            sout_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else if (GAP == 0) begin
                            sout    <= shadow[W-1];
                            shreg   <= {shadow[W-2:0], 1'b0};
                            bit_cnt <= BIT_LAST;
                        end else begin
                            state      <= S_GAP;
                            gap_cnt    <= GAP_LAST;
                            sout       <= 1'b0;
                            sout_valid <= 1'b0;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state      <= S_SHIFT;
                        sout       <= shadow[W-1];
                        sout_valid <= 1'b1;
                        shreg      <= {shadow[W-2:0], 1'b0};
                        bit_cnt    <= BIT_LAST;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                S_DONE: begin
                    state      <= S_IDLE;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    busy       <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: one instance with GAP=0, one with GAP=2, sharing clock and reset.
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start0 = 1'b0;
    logic [3:0] pattern0 = 4'd0;
    logic [7:0] rep0 = 8'd0;
    logic       sout0, valid0, busy0, done0;

    logic       start2 = 1'b0;
    logic [3:0] pattern2 = 4'd0;
    logic [7:0] rep2 = 8'd0;
    logic       sout2, valid2, busy2, done2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // 1101 detector watching the GAP=0 instance
    logic [3:0] det_win = 4'd0;
    int         det_hits = 0;

    always #5 clk = ~clk;

    seq_gen #(.W(4), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pattern(pattern0), .rep(rep0),
        .sout(sout0), .sout_valid(valid0), .busy(busy0), .done(done0)
    );

    seq_gen #(.W(4), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .pattern(pattern2), .rep(rep2),
        .sout(sout2), .sout_valid(valid2), .busy(busy2), .done(done2)
    );

    always @(posedge clk) begin
        if (valid0) begin
            det_win <= {det_win[2:0], sout0};
            if ({det_win[2:0], sout0} == 4'b1101) det_hits <= det_hits + 1;
        end else begin
            det_win <= 4'd0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic s, input logic v, input logic b, input logic d);
        chk({tag, ".sout"},  int'(sout0),  int'(s));
        chk({tag, ".valid"}, int'(valid0), int'(v));
        chk({tag, ".busy"},  int'(busy0),  int'(b));
        chk({tag, ".done"},  int'(done0),  int'(d));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] bits12;
        logic [9:0]  exp_s;
        logic [9:0]  exp_v;
        logic [7:0]  bits8;

        // reset state
        #2;
        chk0("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.dut2.busy", int'(busy2), 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk0("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // single repetition of 1101
        pattern0 = 4'b1101; rep0 = 8'd1; start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        chk0("t1.b0", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t1.b1", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t1.b2", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t1.b3", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t1.done", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(); chk0("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // three back-to-back repetitions
        det_hits = 0;
        bits12 = 12'b1101_1101_1101;
        pattern0 = 4'b1101; rep0 = 8'd3; start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("t2.sout", int'(sout0), int'(bits12[11-i]));
            chk("t2.valid", int'(valid0), 1);
            if (i < 11) cyc();
        end
        cyc();
        chk0("t2.done", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("t2.detector_hits", det_hits, 3);

        // GAP=2 instance, 1011 twice
        exp_s = 10'b1011_00_1011;
        exp_v = 10'b1111_00_1111;
        pattern2 = 4'b1011; rep2 = 8'd2; start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t3.sout",  int'(sout2),  int'(exp_s[9-i]));
            chk("t3.valid", int'(valid2), int'(exp_v[9-i]));
            chk("t3.busy",  int'(busy2),  1);
            cyc();
        end
        chk("t3.done", int'(done2), 1);
        chk("t3.busy_end", int'(busy2), 0);
        cyc();
        chk("t3.done_pulse", int'(done2), 0);

        // empty job
        pattern0 = 4'b1111; rep0 = 8'd0; start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        chk0("t4.done", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        chk0("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // start held high; inputs change mid-job
        pattern0 = 4'b1001; rep0 = 8'd1; start0 = 1'b1;
        cyc();
        pattern0 = 4'b0110; rep0 = 8'd2;
        chk0("t5.b0", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t5.b1", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t5.b2", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t5.b3", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t5.done", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(); chk0("t5.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        start0 = 1'b0;
        bits8 = 8'b0110_0110;
        for (int i = 0; i < 8; i++) begin
            chk("t5.job2.sout",  int'(sout0),  int'(bits8[7-i]));
            chk("t5.job2.valid", int'(valid0), 1);
            cyc();
        end
        chk("t5.job2.done", int'(done0), 1);
        cyc();

        // asynchronous reset mid-shift
        pattern0 = 4'b1101; rep0 = 8'd1; start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        cyc();
        chk0("t6.pre", 1'b1, 1'b1, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk0("t6.async", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk0("t6.held", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc();
        chk0("t6.no_done", 1'b0, 1'b0, 1'b0, 1'b0);
        pattern0 = 4'b1101; rep0 = 8'd1; start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        chk0("t6.r0", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t6.r1", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t6.r2", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t6.r3", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(); chk0("t6.done", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
